// File: rtl/axi_crossbar_rd_decerr.sv
// axi_crossbar_rd_decerr
// Read-side decode-error responder. For each read command flagged with a
// decode error it plays out a full R burst (DECERR, zero data, matching ID)
// and then, optionally, strobes a completion back to the thread tracker.
// Commands without the decode-error flag are accepted and dropped.
//
// Build option: define AXI_DECERR_CPL_EN to include the CPL state and the
// m_cpl_valid/m_cpl_id completion strobe. Without it the completion outputs
// are tied to 0 and the burst returns straight to IDLE after its last beat.

module axi_crossbar_rd_decerr #(
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   s_rc_id,
   input  logic [7:0]            s_rc_len,
   input  logic                  s_rc_decerr,
   input  logic                  s_rc_valid,
   output logic                  s_rc_ready,
   output logic [ID_WIDTH-1:0]   m_axi_rid,
   output logic [DATA_WIDTH-1:0] m_axi_rdata,
   output logic [1:0]            m_axi_rresp,
   output logic                  m_axi_rlast,
   output logic                  m_axi_rvalid,
   input  logic                  m_axi_rready,
   output logic [ID_WIDTH-1:0]   m_cpl_id,
   output logic                  m_cpl_valid
);

   localparam int unsigned LEN_WIDTH = 8;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

`ifdef AXI_DECERR_CPL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CPL  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1
   } state_t;
`endif

   state_t               state;
   logic [ID_WIDTH-1:0]  id_reg;
   logic [LEN_WIDTH-1:0] count_reg;

`ifdef AXI_DECERR_CPL_EN
   logic                 cpl_valid_reg;
   logic [ID_WIDTH-1:0]  cpl_id_reg;
`endif

   // R data is never meaningful for an error burst; ID is the latched command ID
   assign m_axi_rdata = '0;
   assign m_axi_rid   = id_reg;

`ifdef AXI_DECERR_CPL_EN
   assign m_cpl_valid = cpl_valid_reg;
   assign m_cpl_id    = cpl_id_reg;
`else
   assign m_cpl_valid = 1'b0;
   assign m_cpl_id    = '0;
`endif

   // Command admission, burst countdown and completion sequencing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         id_reg       <= '0;
         count_reg    <= '0;
         s_rc_ready   <= 1'b0;
         m_axi_rvalid <= 1'b0;
         m_axi_rlast  <= 1'b0;
         m_axi_rresp  <= 2'b00;
`ifdef AXI_DECERR_CPL_EN
         cpl_valid_reg <= 1'b0;
         cpl_id_reg    <= '0;
`endif
      end else begin
`ifdef AXI_DECERR_CPL_EN
         cpl_valid_reg <= 1'b0;
`endif
         case (state)
            IDLE: begin
               s_rc_ready <= 1'b1;
               // Non-decerr commands handshake here and are simply dropped
               if (s_rc_valid && s_rc_ready && s_rc_decerr) begin
                  id_reg       <= s_rc_id;
                  count_reg    <= s_rc_len;
                  m_axi_rvalid <= 1'b1;
                  m_axi_rresp  <= RESP_DECERR;
                  m_axi_rlast  <= (s_rc_len == LEN_WIDTH'(0));
                  s_rc_ready   <= 1'b0;
                  state        <= DATA;
               end
            end

            DATA: begin
               if (m_axi_rvalid && m_axi_rready) begin
                  if (count_reg != LEN_WIDTH'(0)) begin
                     // rlast is registered one beat ahead of the final handshake
                     count_reg   <= count_reg - LEN_WIDTH'(1);
                     m_axi_rlast <= (count_reg == LEN_WIDTH'(1));
                  end else begin
                     m_axi_rvalid <= 1'b0;
                     m_axi_rlast  <= 1'b0;
                     m_axi_rresp  <= 2'b00;
`ifdef AXI_DECERR_CPL_EN
                     cpl_valid_reg <= 1'b1;
                     cpl_id_reg    <= id_reg;
                     state         <= CPL;
`else
                     s_rc_ready    <= 1'b1;
                     state         <= IDLE;
`endif
                  end
               end
            end

`ifdef AXI_DECERR_CPL_EN
            CPL: begin
               s_rc_ready <= 1'b1;
               state      <= IDLE;
            end
`endif

            default: begin
               s_rc_ready   <= 1'b0;
               m_axi_rvalid <= 1'b0;
               m_axi_rlast  <= 1'b0;
               m_axi_rresp  <= 2'b00;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_crossbar_rd_decerr.sv
// Directed testbench for axi_crossbar_rd_decerr. Expectations follow the
// AXI_DECERR_CPL_EN build option when it is defined for the bench too.

module tb_axi_crossbar_rd_decerr;

   localparam int unsigned ID_WIDTH   = 8;
   localparam int unsigned DATA_WIDTH = 32;

`ifdef AXI_DECERR_CPL_EN
   localparam bit CPL_EN = 1'b1;
`else
   localparam bit CPL_EN = 1'b0;
`endif

   logic                  clk;
   logic                  rst;
   logic [ID_WIDTH-1:0]   s_rc_id;
   logic [7:0]            s_rc_len;
   logic                  s_rc_decerr;
   logic                  s_rc_valid;
   logic                  s_rc_ready;
   logic [ID_WIDTH-1:0]   m_axi_rid;
   logic [DATA_WIDTH-1:0] m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rlast;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;
   logic [ID_WIDTH-1:0]   m_cpl_id;
   logic                  m_cpl_valid;

   int total_cnt;
   int pass_cnt;
   int cpl_cnt;
   int rv_cnt;

   axi_crossbar_rd_decerr #(
      .ID_WIDTH   (ID_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_rc_id      (s_rc_id),
      .s_rc_len     (s_rc_len),
      .s_rc_decerr  (s_rc_decerr),
      .s_rc_valid   (s_rc_valid),
      .s_rc_ready   (s_rc_ready),
      .m_axi_rid    (m_axi_rid),
      .m_axi_rdata  (m_axi_rdata),
      .m_axi_rresp  (m_axi_rresp),
      .m_axi_rlast  (m_axi_rlast),
      .m_axi_rvalid (m_axi_rvalid),
      .m_axi_rready (m_axi_rready),
      .m_cpl_id     (m_cpl_id),
      .m_cpl_valid  (m_cpl_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running counts of completion strobes and valid R cycles
   initial begin
      cpl_cnt = 0;
      rv_cnt  = 0;
   end
   always @(negedge clk) begin
      if (m_cpl_valid === 1'b1) cpl_cnt <= cpl_cnt + 1;
      if (m_axi_rvalid === 1'b1) rv_cnt <= rv_cnt + 1;
   end

   // Present a command at a negedge; it is taken on the following posedge
   task automatic send_cmd(input logic [7:0] id, input logic [7:0] len,
                           input logic dec, output bit ok);
      ok          = 1'b0;
      s_rc_id     = id;
      s_rc_len    = len;
      s_rc_decerr = dec;
      for (int i = 0; i < 20; i++) begin
         if (s_rc_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         s_rc_valid = 1'b1;
         @(negedge clk);
         s_rc_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      total_cnt++; if (s_rc_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", s_rc_ready); else pass_cnt++;
      total_cnt++; if (m_axi_rvalid !== 1'b0) $display("FAIL rst_rvalid got %0b want 0", m_axi_rvalid); else pass_cnt++;
      total_cnt++; if ({m_axi_rlast, m_axi_rresp, m_axi_rid} !== 11'd0) $display("FAIL rst_r got %0h want 0", {m_axi_rlast, m_axi_rresp, m_axi_rid}); else pass_cnt++;
      total_cnt++; if (m_axi_rdata !== 32'd0) $display("FAIL rst_rdata got %0h want 0", m_axi_rdata); else pass_cnt++;
      total_cnt++; if ({m_cpl_valid, m_cpl_id} !== 9'd0) $display("FAIL rst_cpl got %0h want 0", {m_cpl_valid, m_cpl_id}); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (s_rc_ready !== 1'b1) $display("FAIL rst_release_ready got %0b want 1", s_rc_ready); else pass_cnt++;
   endtask

   task automatic test_single_beat();
      bit ok;
      int c0;
      m_axi_rready = 1'b1;
      c0 = cpl_cnt;
      send_cmd(8'h5A, 8'd0, 1'b1, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL single_accept got %0b want 1", ok); else pass_cnt++;
      total_cnt++; if (m_axi_rvalid !== 1'b1) $display("FAIL single_rvalid got %0b want 1", m_axi_rvalid); else pass_cnt++;
      total_cnt++; if (m_axi_rid !== 8'h5A) $display("FAIL single_rid got %0h want 5a", m_axi_rid); else pass_cnt++;
      total_cnt++; if (m_axi_rresp !== 2'b11) $display("FAIL single_rresp got %0d want 3", m_axi_rresp); else pass_cnt++;
      total_cnt++; if (m_axi_rlast !== 1'b1) $display("FAIL single_rlast got %0b want 1", m_axi_rlast); else pass_cnt++;
      total_cnt++; if (m_axi_rdata !== 32'd0) $display("FAIL single_rdata got %0h want 0", m_axi_rdata); else pass_cnt++;
      total_cnt++; if (s_rc_ready !== 1'b0) $display("FAIL single_busy got %0b want 0", s_rc_ready); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({m_axi_rvalid, m_axi_rlast, m_axi_rresp} !== 4'd0) $display("FAIL single_after got %0h want 0", {m_axi_rvalid, m_axi_rlast, m_axi_rresp}); else pass_cnt++;
      total_cnt++; if (m_axi_rid !== 8'h5A) $display("FAIL single_rid_hold got %0h want 5a", m_axi_rid); else pass_cnt++;
      total_cnt++; if (m_cpl_valid !== CPL_EN) $display("FAIL single_cpl_valid got %0b want %0b", m_cpl_valid, CPL_EN); else pass_cnt++;
      total_cnt++; if (m_cpl_id !== (CPL_EN ? 8'h5A : 8'h00)) $display("FAIL single_cpl_id got %0h want %0h", m_cpl_id, CPL_EN ? 8'h5A : 8'h00); else pass_cnt++;
      total_cnt++; if (s_rc_ready !== !CPL_EN) $display("FAIL single_ready_t2 got %0b want %0b", s_rc_ready, !CPL_EN); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (m_cpl_valid !== 1'b0) $display("FAIL single_cpl_width got %0b want 0", m_cpl_valid); else pass_cnt++;
      total_cnt++; if (s_rc_ready !== 1'b1) $display("FAIL single_ready_t3 got %0b want 1", s_rc_ready); else pass_cnt++;
      total_cnt++; if (cpl_cnt - c0 !== int'(CPL_EN)) $display("FAIL single_cpl_count got %0d want %0d", cpl_cnt - c0, CPL_EN); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit ok;
      bit pat [7];
      int beats, bad_last, unstable, c0;
      bit stalled;
      logic [7:0] p_rid;
      logic       p_last;
      logic [1:0] p_resp;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      beats = 0; bad_last = 0; unstable = 0; stalled = 1'b0;
      p_rid = '0; p_last = 1'b0; p_resp = '0;
      c0 = cpl_cnt;
      m_axi_rready = 1'b1;
      send_cmd(8'h33, 8'd3, 1'b1, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL bp_accept got %0b want 1", ok); else pass_cnt++;
      for (int i = 0; i < 7; i++) begin
         if (stalled && (m_axi_rvalid !== 1'b1 || m_axi_rid !== p_rid || m_axi_rlast !== p_last ||
                         m_axi_rresp !== p_resp || m_axi_rdata !== 32'd0))
            unstable++;
         m_axi_rready = pat[i];
         if (m_axi_rvalid === 1'b1 && pat[i]) begin
            beats++;
            if (m_axi_rlast !== (beats == 4)) bad_last++;
         end
         stalled = (m_axi_rvalid === 1'b1) && !pat[i];
         p_rid = m_axi_rid; p_last = m_axi_rlast; p_resp = m_axi_rresp;
         @(negedge clk);
      end
      m_axi_rready = 1'b1;
      total_cnt++; if (beats !== 4) $display("FAIL bp_beats got %0d want 4", beats); else pass_cnt++;
      total_cnt++; if (bad_last !== 0) $display("FAIL bp_rlast got %0d bad beats want 0", bad_last); else pass_cnt++;
      total_cnt++; if (unstable !== 0) $display("FAIL bp_stable got %0d changes want 0", unstable); else pass_cnt++;
      total_cnt++; if (m_axi_rvalid !== 1'b0) $display("FAIL bp_done got %0b want 0", m_axi_rvalid); else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++; if (cpl_cnt - c0 !== int'(CPL_EN)) $display("FAIL bp_cpl_count got %0d want %0d", cpl_cnt - c0, CPL_EN); else pass_cnt++;
   endtask

   task automatic test_max_len();
      bit ok;
      int beats, bad_last, last_at, c0;
      beats = 0; bad_last = 0; last_at = -1;
      c0 = cpl_cnt;
      m_axi_rready = 1'b1;
      send_cmd(8'hC3, 8'd255, 1'b1, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL max_accept got %0b want 1", ok); else pass_cnt++;
      for (int i = 0; i < 300; i++) begin
         if (m_axi_rvalid !== 1'b1) break;
         beats++;
         if (m_axi_rid !== 8'hC3 || m_axi_rresp !== 2'b11) bad_last++;
         if (m_axi_rlast === 1'b1) begin
            if (last_at < 0) last_at = beats; else bad_last++;
         end
         @(negedge clk);
      end
      total_cnt++; if (beats !== 256) $display("FAIL max_beats got %0d want 256", beats); else pass_cnt++;
      total_cnt++; if (last_at !== 256) $display("FAIL max_rlast_pos got %0d want 256", last_at); else pass_cnt++;
      total_cnt++; if (bad_last !== 0) $display("FAIL max_beat_fields got %0d bad want 0", bad_last); else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++; if (cpl_cnt - c0 !== int'(CPL_EN)) $display("FAIL max_cpl_count got %0d want %0d", cpl_cnt - c0, CPL_EN); else pass_cnt++;
      total_cnt++; if (s_rc_ready !== 1'b1) $display("FAIL max_ready got %0b want 1", s_rc_ready); else pass_cnt++;
   endtask

   task automatic test_discard();
      int c0, r0;
      c0 = cpl_cnt;
      r0 = rv_cnt;
      m_axi_rready = 1'b1;
      s_rc_decerr  = 1'b0;
      s_rc_len     = 8'd4;
      s_rc_valid   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_rc_id = 8'(8'h10 + i);
         total_cnt++; if (s_rc_ready !== 1'b1) $display("FAIL discard_ready%0d got %0b want 1", i, s_rc_ready); else pass_cnt++;
         @(negedge clk);
      end
      s_rc_valid = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (rv_cnt - r0 !== 0) $display("FAIL discard_rvalid got %0d cycles want 0", rv_cnt - r0); else pass_cnt++;
      total_cnt++; if (cpl_cnt - c0 !== 0) $display("FAIL discard_cpl got %0d want 0", cpl_cnt - c0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      int beats, c0;
      beats = 0;
      c0 = cpl_cnt;
      m_axi_rready = 1'b1;
      send_cmd(8'h77, 8'd7, 1'b1, ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL mid_accept got %0b want 1", ok); else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
         if (m_axi_rvalid === 1'b1) beats++;
         if (beats == 3) break;
         @(negedge clk);
      end
      total_cnt++; if (beats !== 3) $display("FAIL mid_beats got %0d want 3", beats); else pass_cnt++;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (m_axi_rvalid !== 1'b0) $display("FAIL mid_rvalid got %0b want 0", m_axi_rvalid); else pass_cnt++;
      total_cnt++; if ({m_axi_rlast, m_axi_rresp, m_axi_rid} !== 11'd0) $display("FAIL mid_r got %0h want 0", {m_axi_rlast, m_axi_rresp, m_axi_rid}); else pass_cnt++;
      total_cnt++; if ({s_rc_ready, m_cpl_valid, m_cpl_id} !== 10'd0) $display("FAIL mid_ctl got %0h want 0", {s_rc_ready, m_cpl_valid, m_cpl_id}); else pass_cnt++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total_cnt++; if (s_rc_ready !== 1'b1) $display("FAIL mid_release_ready got %0b want 1", s_rc_ready); else pass_cnt++;
      total_cnt++; if (cpl_cnt - c0 !== 0) $display("FAIL mid_no_cpl got %0d want 0", cpl_cnt - c0); else pass_cnt++;
      send_cmd(8'h12, 8'd1, 1'b1, ok);
      total_cnt++; if ({ok, m_axi_rvalid, m_axi_rlast, m_axi_rid} !== {1'b1, 1'b1, 1'b0, 8'h12}) $display("FAIL fresh_beat1 got %0h want %0h", {ok, m_axi_rvalid, m_axi_rlast, m_axi_rid}, {1'b1, 1'b1, 1'b0, 8'h12}); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({m_axi_rvalid, m_axi_rlast} !== 2'b11) $display("FAIL fresh_beat2 got %0b want 11", {m_axi_rvalid, m_axi_rlast}); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (m_axi_rvalid !== 1'b0) $display("FAIL fresh_done got %0b want 0", m_axi_rvalid); else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++; if (cpl_cnt - c0 !== int'(CPL_EN)) $display("FAIL fresh_cpl got %0d want %0d", cpl_cnt - c0, CPL_EN); else pass_cnt++;
   endtask

   initial begin
      total_cnt    = 0;
      pass_cnt     = 0;
      rst          = 1'b1;
      s_rc_id      = '0;
      s_rc_len     = '0;
      s_rc_decerr  = 1'b0;
      s_rc_valid   = 1'b0;
      m_axi_rready = 1'b0;
      test_reset();
      test_single_beat();
      test_backpressure();
      test_max_len();
      test_discard();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
